// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared opcodes, state encoding and opcode legality check for alu_pipe
// Contents:
//   OP_* localparams : 4-bit operation codes
//   state_t          : IDLE / MUL sequencing states
//   is_legal_op()    : 1 when a code names a supported operation
package alu_pipe_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // MUL only counts as legal when the multiplier is built into the block.
  function automatic logic is_legal_op(input logic [3:0] op, input logic mul_en);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SLTU, OP_SUB, OP_SLT,
      OP_SLL, OP_SRL, OP_SRA, OP_NOR: legal = 1'b1;
      OP_MUL:                         legal = mul_en;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add multiplier, low WIDTH bits of the unsigned product
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and begin WIDTH shift-add steps
//   a, b       : multiplicand, multiplier (sampled on start)
//   done       : high for the one cycle after the last step completes
//   product    : accumulated product, valid while done is high
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    count_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      count_q  <= CW'(WIDTH);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (count_q != '0) begin
        // Bits shifted out of the top of mcand only affect product bits above WIDTH.
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        count_q  <= count_q - 1'b1;
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  // The count==0 cycle is the hand-off cycle: the owner registers product here.
  assign done    = busy_q && (count_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshakes, shifts and an iterative multiplier
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation handshake (src1, src2, ALU_control)
//   src1, src2          : operands; src2 low $clog2(WIDTH) bits are the shift amount
//   ALU_control         : 4-bit operation code
//   out_valid/out_ready : result handshake
//   result              : registered result
//   zero, cout, overflow: result flags, held together with result
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int   SW     = $clog2(WIDTH);
  localparam int   MSB    = WIDTH - 1;
  localparam logic MUL_ON = (MUL_EN != 0);

  state_t state_q;
  state_t state_d;

  logic             accept;
  logic             is_mul_op;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic             ovf_add;
  logic             ovf_sub;
  logic             slt_bit;
  logic             sltu_bit;
  logic [SW-1:0]    shamt;

  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_ovf;
  logic             alu_legal;

  logic [WIDTH-1:0] result_q;
  logic             zero_ok_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;

  // Handshake: a held, unconsumed result blocks new work, as does a running multiply.
  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul_op = MUL_ON && (ALU_control == OP_MUL);
  assign mul_start = accept && is_mul_op;

  // Add/sub share one adder shape; SUB is A + ~B + 1 so its carry means "no borrow".
  assign sum_add  = {1'b0, src1} + {1'b0, src2};
  assign sum_sub  = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};
  assign ovf_add  = (src1[MSB] == src2[MSB]) && (sum_add[MSB] != src1[MSB]);
  assign ovf_sub  = (src1[MSB] != src2[MSB]) && (sum_sub[MSB] != src1[MSB]);
  // Sign of the difference corrected by overflow gives the true signed compare.
  assign slt_bit  = sum_sub[MSB] ^ ovf_sub;
  assign sltu_bit = ~sum_sub[WIDTH];
  assign shamt    = src2[SW-1:0];

  always_comb begin
    alu_res   = '0;
    alu_cout  = 1'b0;
    alu_ovf   = 1'b0;
    alu_legal = is_legal_op(ALU_control, MUL_ON);
    case (ALU_control)
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_NOR:  alu_res = ~(src1 | src2);
      OP_ADD: begin
        alu_res  = sum_add[WIDTH-1:0];
        alu_cout = sum_add[WIDTH];
        alu_ovf  = ovf_add;
      end
      OP_SUB: begin
        alu_res  = sum_sub[WIDTH-1:0];
        alu_cout = sum_sub[WIDTH];
        alu_ovf  = ovf_sub;
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, sltu_bit};
      OP_SLL:  alu_res = src1 << shamt;
      OP_SRL:  alu_res = src1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(src1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_seq #(
        .WIDTH (WIDTH)
      ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (src1),
        .b       (src2),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (mul_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output register. A single-cycle accept on the same edge as out_ready keeps
  // out_valid high with the new result; a MUL accept lets the old result drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_ok_q   <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept && !is_mul_op) begin
      result_q    <= alu_res;
      zero_ok_q   <= alu_legal;
      cout_q      <= alu_cout;
      ovf_q       <= alu_ovf;
      out_valid_q <= 1'b1;
    end else if (mul_done) begin
      result_q    <= mul_product;
      zero_ok_q   <= 1'b1;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Illegal codes register a zero result but must report zero = 0, hence the qualifier.
  assign zero      = zero_ok_q && (result_q == '0);
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe against an arithmetic reference model
module tb_alu_pipe;

  localparam logic [3:0] C_AND = 4'd0, C_OR = 4'd1, C_ADD = 4'd2, C_SLTU = 4'd3;
  localparam logic [3:0] C_SUB = 4'd6, C_SLT = 4'd7, C_MUL = 4'd8, C_SLL = 4'd9;
  localparam logic [3:0] C_SRL = 4'd10, C_SRA = 4'd11, C_NOR = 4'd12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  ALU_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] op_tbl [0:12];

  alu_pipe #(
    .WIDTH  (32),
    .MUL_EN (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src1        (src1),
    .src2        (src2),
    .ALU_control (ALU_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .cout        (cout),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ovf_range(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Reference behaviour from plain integer arithmetic on 64-bit values.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic c, output logic v,
                                    output logic z);
    longint unsigned u;
    longint          s;
    logic            legal;
    r = 32'd0; c = 1'b0; v = 1'b0; legal = 1'b1;
    case (op)
      C_AND:  r = a & b;
      C_OR:   r = a | b;
      C_NOR:  r = ~(a | b);
      C_ADD: begin
        u = longint'(a) + longint'(b);
        r = u[31:0];
        c = (u > 64'd4294967295);
        s = longint'($signed(a)) + longint'($signed(b));
        v = ovf_range(s);
      end
      C_SUB: begin
        r = a - b;
        c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = ovf_range(s);
      end
      C_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      C_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      C_MUL: begin
        u = longint'(a) * longint'(b);
        r = u[31:0];
      end
      C_SLL:  r = a << b[4:0];
      C_SRL:  r = a >> b[4:0];
      C_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      default: legal = 1'b0;
    endcase
    z = legal && (r == 32'd0);
  endfunction

  // Issue one operation, check latency and outputs, optionally hold the result for
  // 'hold' cycles of backpressure, then let it drain.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    logic [31:0] er;
    logic        ec, ev, ez;
    int          k;
    int          lat;
    ref_model(op, a, b, er, ec, ev, ez);
    in_valid    = 1'b1;
    ALU_control = op;
    src1        = a;
    src2        = b;
    out_ready   = (hold == 0);
    k = 0;
    while (!in_ready && k < 200) begin
      step();
      k++;
    end
    check("accept_wait", 64'(k < 200), 64'd1);
    step();
    in_valid = 1'b0;
    src1     = $urandom;
    src2     = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (op == C_MUL) check("mul_in_ready", 64'(in_ready), 64'd0);
      step();
      lat++;
    end
    check("latency", 64'(lat), (op == C_MUL) ? 64'd33 : 64'd0);
    check("result", 64'(result), 64'(er));
    check("cout", 64'(cout), 64'(ec));
    check("overflow", 64'(overflow), 64'(ev));
    check("zero", 64'(zero), 64'(ez));
    for (int i = 0; i < hold; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      step();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_result", 64'(result), 64'(er));
    end
    out_ready = 1'b1;
    step();
    check("drain", 64'(out_valid), 64'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    logic [31:0] bp_exp;

    op_tbl[0] = C_AND;  op_tbl[1] = C_OR;   op_tbl[2]  = C_ADD; op_tbl[3]  = C_SLTU;
    op_tbl[4] = C_SUB;  op_tbl[5] = C_SLT;  op_tbl[6]  = C_MUL; op_tbl[7]  = C_SLL;
    op_tbl[8] = C_SRL;  op_tbl[9] = C_SRA;  op_tbl[10] = C_NOR; op_tbl[11] = 4'd4;
    op_tbl[12] = 4'd15;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    src1        = '0;
    src2        = '0;
    ALU_control = '0;
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    #3 rst_n = 1'b1;
    step();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed corner cases.
    do_op(C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    do_op(C_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op(C_SUB, 32'd5, 32'd5, 0);
    do_op(C_SUB, 32'h8000_0000, 32'h0000_0001, 0);
    do_op(C_SLT, 32'h8000_0000, 32'h0000_0001, 0);
    do_op(C_SLTU, 32'h8000_0000, 32'h0000_0001, 0);
    do_op(C_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    do_op(C_MUL, 32'h0001_0003, 32'h0000_0005, 0);
    do_op(C_SRA, 32'h8000_0000, 32'h0000_0024, 0);
    do_op(C_SRL, 32'h8000_0000, 32'h0000_0024, 0);
    do_op(C_SLL, 32'h0000_0001, 32'd31, 0);
    do_op(C_NOR, 32'h0F0F_0000, 32'h0000_F0F0, 0);
    do_op(4'd5, 32'h1234_5678, 32'h1234_5678, 0);
    do_op(4'd15, 32'h0, 32'h0, 1);

    // Backpressure with in_valid held high, then same-edge consume/accept.
    in_valid    = 1'b1;
    ALU_control = C_ADD;
    src1        = 32'd100;
    src2        = 32'd23;
    out_ready   = 1'b0;
    check("bp_pre_ready", 64'(in_ready), 64'd1);
    step();
    ALU_control = C_SUB;
    src1        = 32'd9;
    src2        = 32'd4;
    check("bp_first_valid", 64'(out_valid), 64'd1);
    check("bp_first_result", 64'(result), 64'd123);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_ready", 64'(in_ready), 64'd0);
      step();
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_result", 64'(result), 64'd123);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    ref_model(C_SUB, 32'd9, 32'd4, bp_exp, ra[0], ra[1], ra[2]);
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_result", 64'(result), 64'(bp_exp));
    step();
    check("b2b_drain", 64'(out_valid), 64'd0);

    // Randomised operations with random backpressure.
    for (int n = 0; n < 150; n++) begin
      rop = op_tbl[$urandom_range(0, 12)];
      ra  = rand_operand();
      rb  = rand_operand();
      do_op(rop, ra, rb, int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a multiply discards it.
    in_valid    = 1'b1;
    ALU_control = C_MUL;
    src1        = 32'h0001_0003;
    src2        = 32'h0000_0005;
    check("mr_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    check("mr_busy", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_result", 64'(result), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check("mr_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 40; i++) begin
      check("mr_no_stale", 64'(out_valid), 64'd0);
      step();
    end
    do_op(C_ADD, 32'd2, 32'd3, 0);
    do_op(C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor of the 32-bit registered ALU.
- Adds:
  - configurable WIDTH
  - valid/ready handshakes on input and output
  - shift operations (SLL/SRL/SRA) and unsigned SLTU
  - a multi-cycle iterative multiplier (MUL)
- Sits between the register-read stage and writeback in the datapath. The execute stage stalls on in_ready.

Parameters:
- WIDTH, 32, datapath width. Must be a power of 2 and at least 4.
- MUL_EN, 1, enables MUL. When 0, code 1000 is treated as an illegal code.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and code are valid.
- in_ready  output  1  block accepts an operation this cycle.
- src1  input  WIDTH  operand A.
- src2  input  WIDTH  operand B. Low $clog2(WIDTH) bits are the shift amount for shifts.
- ALU_control  input  4  operation code.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- cout  output  1  carry out (ADD/SUB only).
- overflow  output  1  signed overflow (ADD/SUB only).

Behaviour:
- Reset (asynchronous, any state, including mid-MUL):
  - state = IDLE; out_valid = 0; result = 0; zero = 0; cout = 0; overflow = 0; multiplier registers cleared.
  - Any in-flight operation is discarded.
  - in_ready = 1 in the first cycle after rst_n deasserts.
- Accept condition: in_valid && in_ready at a rising clk.
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
- Operation codes:
  - AND 0000, OR 0001, ADD 0010, SLTU 0011, SUB 0110, SLT 0111, MUL 1000, SLL 1001, SRL 1010, SRA 1011, NOR 1100.
  - Every other code is illegal: result = 0, all flags 0, handshake completes normally with latency 1.
- Single-cycle operations: result and flags are registered on the accept edge; out_valid = 1 on the next cycle (latency 1).
- ADD:
  - {cout, result} = A + B.
  - overflow = (A[MSB] == B[MSB]) && (result[MSB] != A[MSB]).
- SUB:
  - Computed as A + ~B + 1; cout is the carry of that sum, so 1 means no borrow.
  - overflow = (A[MSB] != B[MSB]) && (result[MSB] != A[MSB]).
- SLT: result = {0..., (A-B)[MSB] XOR ovf_sub}. Correct even when the subtraction overflows.
- SLTU: result = {0..., A < B unsigned}.
- SLT/SLTU/logic/shift/MUL: cout = 0 and overflow = 0.
- Shifts:
  - Shift amount = src2[$clog2(WIDTH)-1:0]; upper src2 bits are ignored.
  - SRA replicates A[MSB].
- MUL (low WIDTH bits of unsigned product, shift-add):
  - On accept, load multiplicand, multiplier and accumulator; state = MUL; count = WIDTH.
  - Each cycle in MUL: one shift-add step, count decrements.
  - When count reaches 0: result is registered, out_valid = 1, state = IDLE.
  - out_valid rises exactly WIDTH+1 cycles after the accept edge.
  - in_ready = 0 throughout MUL.
- Output holding:
  - While out_valid && !out_ready: result and all flags stay stable and no new operation is accepted.
  - out_valid clears on out_ready unless a new accept happens on the same edge. In that case out_valid stays 1 with the new single-cycle result (back-to-back throughput of 1 per cycle).
- Output rules:
  - zero is always computed from the registered result.
  - All outputs change only on clk edges or on reset.
- States:
  - IDLE: accepts operations.
  - MUL: iterating.
  - Output-held backpressure is not a separate state; it is expressed through the in_ready equation.

Decomposition:
- Package alu_pipe_pkg:
  - 4-bit opcode localparams (names as listed above).
  - State encoding IDLE/MUL.
  - A function returning the legal-opcode check.
- One sub-module alu_mul_seq: WIDTH-parametrised iterative multiplier.
  - Ports: start, a, b, done, product.
  - Instantiated only when MUL_EN = 1 (generate).
- Shifts, logic and add/sub stay inline in alu_pipe.

Test Plan:
1. ADD 0x7FFFFFFF + 0x00000001, out_ready = 1 → one cycle after accept: result 0x80000000, overflow 1, cout 0, zero 0.
2. SUB 5 − 5 → result 0, zero 1, cout 1. SLT 0x80000000 vs 0x00000001 → 1. SLTU same operands → 0.
3. MUL 0x00010003 × 0x00000005 → result 0x0005000F; out_valid exactly 33 cycles after accept; in_ready low for all 33 cycles.
4. SRA 0x80000000, src2 = 0x24 → 0xF8000000 (amount 4). SRL same operands → 0x08000000. SLL 0x1 by 31 → 0x80000000.
5. Backpressure: ADD result, out_ready held low 3 cycles while in_valid stays high → result stable, in_ready 0. out_ready rises → next op accepted on the same edge, new result the following cycle.
6. rst_n pulsed low mid-MUL (cycle 10) → out_valid 0, result 0 immediately. After release: in_ready 1; a fresh ADD 2 + 3 returns 5.
